// File: rtl/fp_normalize.sv
// rtl/fp_normalize.sv - FPU normalization stage: leading-one search, exponent adjust, pack with GRS and flags
module fp_normalize #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [49:0] mant_i,
  input  logic        sticky_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [56:0] data_o,
  output logic [2:0]  grs_o,
  output logic        ovf_o,
  output logic        unf_o,
  output logic        zero_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_SHIFT,
    S_PACK,
    S_OUT
  } state_t;

  localparam logic signed [10:0] EXP_MAX  = 11'sd255;
  localparam logic signed [10:0] EXP_MIN  = 11'sd0;
  localparam logic signed [10:0] EXP_STEP = 11'(SHIFT_STEP);

  state_t state, state_nxt;

  logic                   sign_q;
  logic signed [10:0]     exp_q;
  logic [49:0]            mant_q;
  logic                   sticky_q;

  // Window examined per SHIFT cycle: the SHIFT_STEP bits starting at the hidden-bit position.
  logic [SHIFT_STEP-1:0]  win;
  logic [4:0]             win_lzc;
  logic                   win_found;
  logic                   mant_zero;

  assign win       = mant_q[48 -: SHIFT_STEP];
  assign mant_zero = (mant_q == 50'd0);

  // Leading-zero count of the window (only meaningful when the window is non-zero).
  always_comb begin
    win_lzc   = 5'(SHIFT_STEP);
    win_found = 1'b0;
    for (int i = SHIFT_STEP - 1; i >= 0; i--) begin
      if (!win_found && win[i]) begin
        win_lzc   = 5'(SHIFT_STEP - 1 - i);
        win_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = S_EVAL;
      end
      S_EVAL: begin
        if (mant_zero || mant_q[49] || mant_q[48]) state_nxt = S_PACK;
        else                                        state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (win_found) state_nxt = S_PACK;
      end
      S_PACK: begin
        state_nxt = S_OUT;
      end
      S_OUT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, normalization shifts and result packing.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      sticky_q <= 1'b0;
      data_o   <= '0;
      grs_o    <= '0;
      ovf_o    <= 1'b0;
      unf_o    <= 1'b0;
      zero_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid_i) begin
            sign_q   <= sign_i;
            exp_q    <= {exp_i[9], exp_i};
            mant_q   <= mant_i;
            sticky_q <= sticky_i;
          end
        end
        S_EVAL: begin
          // Carry into bit 49: one right shift, the lost LSB folds into sticky.
          if (mant_q[49]) begin
            mant_q   <= mant_q >> 1;
            exp_q    <= exp_q + 11'sd1;
            sticky_q <= sticky_q | mant_q[0];
          end
        end
        S_SHIFT: begin
          if (!win_found) begin
            mant_q <= mant_q << SHIFT_STEP;
            exp_q  <= exp_q - EXP_STEP;
          end else begin
            mant_q <= mant_q << win_lzc;
            exp_q  <= exp_q - $signed({6'd0, win_lzc});
          end
        end
        S_PACK: begin
          ovf_o  <= 1'b0;
          unf_o  <= 1'b0;
          zero_o <= 1'b0;
          grs_o  <= 3'b000;
          if (mant_zero) begin
            zero_o <= 1'b1;
            data_o <= {sign_q, 56'd0};
          end else if (exp_q >= EXP_MAX) begin
            ovf_o  <= 1'b1;
            data_o <= {sign_q, 8'hFF, 48'd0};
          end else if (exp_q <= EXP_MIN) begin
            unf_o  <= 1'b1;
            data_o <= {sign_q, 56'd0};
          end else begin
            data_o <= {sign_q, exp_q[7:0], mant_q[47:25], 25'd0};
            grs_o  <= {mant_q[24], mant_q[23], (|mant_q[22:0]) | sticky_q};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize.sv
// tb/tb_fp_normalize.sv - randomized self-checking bench for fp_normalize against a behavioural model
module tb_fp_normalize;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        sign_i;
  logic [9:0]  exp_i;
  logic [49:0] mant_i;
  logic        sticky_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [56:0] data_o;
  logic [2:0]  grs_o;
  logic        ovf_o;
  logic        unf_o;
  logic        zero_o;

  int n_tests = 0;
  int n_fail  = 0;

  fp_normalize #(.SHIFT_STEP(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .mant_i      (mant_i),
    .sticky_i    (sticky_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .grs_o       (grs_o),
    .ovf_o       (ovf_o),
    .unf_o       (unf_o),
    .zero_o      (zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, req);
    end
  endtask

  // Reference: locate the leading one, shift it to bit 48, then apply the packing rules.
  task automatic model(input logic s, input int e_in, input logic [49:0] m_in, input logic st_in,
                       output logic [56:0] d, output logic [2:0] g,
                       output logic [2:0] flags, output int lat);
    int          p;
    int          e;
    int          lz;
    logic [49:0] m;
    logic        st;
    p = -1;
    for (int i = 0; i < 50; i++) if (m_in[i]) p = i;
    e = e_in; m = m_in; st = st_in;
    d = '0; g = '0; flags = '0; lat = 3;
    if (p < 0) begin
      flags = 3'b001;
      d     = {s, 56'd0};
    end else begin
      if (p == 49) begin
        m  = m_in >> 1;
        e  = e + 1;
        st = st | m_in[0];
      end else if (p < 48) begin
        lz  = 48 - p;
        m   = m_in << lz;
        e   = e - lz;
        lat = 3 + lz / 8 + 1;
      end
      if (e >= 255) begin
        flags = 3'b100;
        d     = {s, 8'hFF, 48'd0};
      end else if (e <= 0) begin
        flags = 3'b010;
        d     = {s, 56'd0};
      end else begin
        d = {s, e[7:0], m[47:25], 25'd0};
        g = {m[24], m[23], (|m[22:0]) | st};
      end
    end
  endtask

  task automatic run(input logic s, input int e, input logic [49:0] m, input logic st, input int hold);
    logic [56:0] d;
    logic [2:0]  g;
    logic [2:0]  flags;
    int          lat;
    int          cyc;
    logic        got;
    model(s, e, m, st, d, g, flags, lat);
    @(negedge clk_i);
    check("in_ready_idle", 64'(in_ready_o), 64'd1);
    sign_i = s; exp_i = 10'(e); mant_i = m; sticky_i = st; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    sign_i = ~s; exp_i = 10'($urandom); mant_i = {18'($urandom), $urandom}; sticky_i = ~st;
    cyc = 1; got = 1'b0;
    while (cyc < 100 && !got) begin
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
      got = out_valid_o;
    end
    if (!got) begin
      check("out_valid_timeout", 64'd0, 64'd1);
      return;
    end
    check("latency", 64'(cyc), 64'(lat));
    check("data", 64'(data_o), 64'(d));
    check("grs", 64'(grs_o), 64'(g));
    check("flags", 64'({ovf_o, unf_o, zero_o}), 64'(flags));
    check("in_ready_busy", 64'(in_ready_o), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("hold_valid", 64'(out_valid_o), 64'd1);
      check("hold_data", 64'(data_o), 64'(d));
      check("hold_grs_flags", 64'({grs_o, ovf_o, unf_o, zero_o}), 64'({g, flags}));
      check("hold_in_ready", 64'(in_ready_o), 64'd0);
    end
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    @(negedge clk_i);
    check("after_hs_valid", 64'(out_valid_o), 64'd0);
    check("after_hs_ready", 64'(in_ready_o), 64'd1);
    check("after_hs_data", 64'(data_o), 64'(d));
  endtask

  initial begin
    logic [63:0] r;
    logic [49:0] m;
    int          p;
    int          e;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    sign_i = 1'b0; exp_i = '0; mant_i = '0; sticky_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_in_ready", 64'(in_ready_o), 64'd1);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_grs_flags", 64'({grs_o, ovf_o, unf_o, zero_o}), 64'd0);
    rst_i = 1'b0;

    run(1'b0, 127, 50'd1 << 48, 1'b0, 0);
    run(1'b0, 127, (50'd1 << 49) | 50'd1, 1'b0, 0);
    run(1'b0, 150, 50'd1 << 28, 1'b0, 0);
    run(1'b0, 254, 50'd1 << 49, 1'b0, 0);
    run(1'b0, 10, 50'd1 << 28, 1'b0, 0);
    run(1'b1, 100, 50'd0, 1'b1, 0);
    run(1'b0, 127, (50'd1 << 48) | (50'd1 << 24) | 50'd1, 1'b0, 0);
    run(1'b0, 127, 50'd1, 1'b1, 5);
    run(1'b1, 255, 50'd1 << 48, 1'b0, 0);
    run(1'b0, 1, 50'd1 << 48, 1'b0, 0);
    run(1'b0, 0, 50'd1 << 48, 1'b0, 0);
    run(1'b1, -256, 50'd3 << 48, 1'b0, 0);
    run(1'b0, 511, 50'd1 << 47, 1'b0, 1);
    run(1'b0, 60, 50'd1 << 40, 1'b0, 0);

    for (int n = 0; n < 300; n++) begin
      p = int'($urandom_range(0, 50));
      r = {$urandom, $urandom};
      if (p == 50) m = '0;
      else m = (50'(r) & ((50'd1 << p) - 50'd1)) | (50'd1 << p);
      e = int'($urandom_range(0, 767)) - 256;
      run(1'($urandom), e, m, 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset while the shifter is iterating: the operation must vanish.
    @(negedge clk_i);
    sign_i = 1'b0; exp_i = 10'd100; mant_i = 50'd1; sticky_i = 1'b0; in_valid_i = 1'b1;
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("midrst_valid", 64'(out_valid_o), 64'd0);
      check("midrst_ready", 64'(in_ready_o), 64'd1);
    end
    check("midrst_data", 64'(data_o), 64'd0);
    run(1'b1, 130, 50'd1 << 30, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
